// File: rtl/smi_pkg.sv
// smi_pkg: shared SMI flit constants, width helpers and arbiter state type.
package smi_pkg;
  localparam int SMI_EOFC_WIDTH = 8;
  localparam logic [7:0] SMI_FRAME_WRITE_REQ = 8'h01;
  localparam logic [7:0] SMI_FRAME_READ_REQ = 8'h02;
  localparam logic [7:0] SMI_FRAME_ID_MASK = 8'hFF;
  typedef enum logic {IDLE, LOCKED} arb_state_t;
  function automatic int smi_data_width(input int flit_bytes);
    return flit_bytes * 8;
  endfunction
  function automatic logic smi_is_eof(input logic [SMI_EOFC_WIDTH-1:0] eofc);
    return eofc != '0;
  endfunction
endpackage

// File: rtl/smi_flit_skid_buffer.sv
// smi_flit_skid_buffer: two-entry Ready/Stop buffer for Eofc+Data with registered outputs.
// Stop is raised only when both entries are occupied, so 1 flit/cycle flows with no downstream stall.
module smi_flit_skid_buffer import smi_pkg::*; #(
  parameter int DataWidth = 128
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      in_ready,
  input  logic [SMI_EOFC_WIDTH-1:0] in_eofc,
  input  logic [DataWidth-1:0]      in_data,
  output logic                      in_stop,
  output logic                      out_ready,
  output logic [SMI_EOFC_WIDTH-1:0] out_eofc,
  output logic [DataWidth-1:0]      out_data,
  input  logic                      out_stop
);
  typedef struct packed {
    logic [SMI_EOFC_WIDTH-1:0] eofc;
    logic [DataWidth-1:0]      data;
  } entry_t;
  entry_t head, tail, in_entry;
  logic [1:0] count;
  logic push, pop, load_head, load_tail;
  assign in_entry = '{eofc: in_eofc, data: in_data};
  assign in_stop = count == 2'd2;
  assign out_ready = count != 2'd0;
  assign out_eofc = head.eofc;
  assign out_data = head.data;
  assign push = in_ready && !in_stop;
  assign pop = out_ready && !out_stop;
  // head takes the new flit when empty, or when its only entry leaves in the same cycle
  assign load_head = push && (count == 2'd0 || (pop && count == 2'd1));
  assign load_tail = push && count == 2'd1 && !pop;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= load_head ? in_entry : ((pop && count == 2'd2) ? tail : head);
      tail  <= load_tail ? in_entry : tail;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/smi_frame_arbiter_xn.sv
// smi_frame_arbiter_xn: N-input SMI frame arbiter, whole frames only, round-robin with skid output.
// Define SMI_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
module smi_frame_arbiter_xn import smi_pkg::*; #(
  parameter int NumInputs  = 4,
  parameter int FlitWidth  = 16,
  parameter int GrantWidth = $clog2(NumInputs)
) (
  input  logic                                clk,
  input  logic                                arstN,
  input  logic [NumInputs-1:0]                inReady,
  input  logic [SMI_EOFC_WIDTH*NumInputs-1:0] inEofc,
  input  logic [FlitWidth*8*NumInputs-1:0]    inData,
  output logic [NumInputs-1:0]                inStop,
  output logic                                outReady,
  output logic [SMI_EOFC_WIDTH-1:0]           outEofc,
  output logic [FlitWidth*8-1:0]              outData,
  input  logic                                outStop
);
  localparam int DataWidth = smi_data_width(FlitWidth);
  arb_state_t state, state_nxt;
  logic [GrantWidth-1:0] grant, grant_nxt, start, win;
  logic found, sel_ready, skid_full, accept, last;
  logic [SMI_EOFC_WIDTH-1:0] sel_eofc;
  logic [DataWidth-1:0] sel_data;
  logic [SMI_EOFC_WIDTH-1:0] eofc_ch [NumInputs];
  logic [DataWidth-1:0] data_ch [NumInputs];
  for (genvar g = 0; g < NumInputs; g++) begin : g_unpack
    assign eofc_ch[g] = inEofc[g*SMI_EOFC_WIDTH +: SMI_EOFC_WIDTH];
    assign data_ch[g] = inData[g*DataWidth +: DataWidth];
  end
  assign sel_ready = inReady[grant];
  assign sel_eofc = eofc_ch[grant];
  assign sel_data = data_ch[grant];
  assign accept = state == LOCKED && sel_ready && !skid_full;
  assign last = accept && smi_is_eof(sel_eofc);
`ifdef SMI_ARB_FIXED_PRIORITY_EN
  assign start = '0;
`else
  logic [GrantWidth-1:0] rr_ptr;
  always_ff @(posedge clk or negedge arstN) begin
    if (!arstN) rr_ptr <= '0;
    else if (last) rr_ptr <= (grant == GrantWidth'(NumInputs - 1)) ? '0 : grant + 1'b1;
  end
  assign start = rr_ptr;
`endif
  // first requester found walking upward from start, wrapping at NumInputs
  always_comb begin
    found = 1'b0;
    win = start;
    for (int i = 0; i < NumInputs; i++) begin
      if (!found && inReady[GrantWidth'((int'(start) + i) % NumInputs)]) begin
        found = 1'b1;
        win = GrantWidth'((int'(start) + i) % NumInputs);
      end
    end
  end
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    inStop = '1;
    if (state == IDLE && found) begin
      state_nxt = LOCKED;
      grant_nxt = win;
    end
    if (last) state_nxt = IDLE;
    if (state == LOCKED) inStop[grant] = skid_full;
  end
  always_ff @(posedge clk or negedge arstN) begin
    if (!arstN) begin
      state <= IDLE;
      grant <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end
  smi_flit_skid_buffer #(.DataWidth(DataWidth)) u_skid (
    .clk      (clk),
    .arst_n   (arstN),
    .in_ready (state == LOCKED && sel_ready),
    .in_eofc  (sel_eofc),
    .in_data  (sel_data),
    .in_stop  (skid_full),
    .out_ready(outReady),
    .out_eofc (outEofc),
    .out_data (outData),
    .out_stop (outStop)
  );
endmodule

// File: tb/tb_smi_frame_arbiter_xn.sv
// tb_smi_frame_arbiter_xn: table-driven frame-order vectors plus reset/latency and mid-frame reset sequences.
module tb_smi_frame_arbiter_xn;
  localparam int NI = 4;
  localparam int DW = 128;
  localparam int W = DW + 8;
  typedef struct packed {
    logic [7:0]    eofc;
    logic [DW-1:0] data;
  } flit_t;
  typedef struct packed {
    logic [NI-1:0] req;
    logic [7:0]    nflit;
    logic [7:0]    nfr;
    logic [7:0]    eofc;
    logic          stop;
    logic [7:0]    n;
    logic [31:0]   order;
  } vec_t;
  logic clk = 1'b0;
  logic arstN = 1'b0;
  logic [NI-1:0] inReady = '0;
  logic [8*NI-1:0] inEofc = '0;
  logic [DW*NI-1:0] inData = '0;
  logic [NI-1:0] inStop;
  logic outReady;
  logic [7:0] outEofc;
  logic [DW-1:0] outData;
  logic outStop = 1'b0;
  flit_t src [NI][$];
  flit_t sb [$];
  int frames [$];
  int checks = 0, errors = 0, seq = 0;
  logic [NI-1:0] took;
  bit toggle_stop, watch_skid, in_frame, out_mid;
  int occ, cur, frame_tag;
  int acc_cnt [NI];
  vec_t vt [5];
  smi_frame_arbiter_xn #(.NumInputs(NI), .FlitWidth(16)) dut (
    .clk(clk), .arstN(arstN), .inReady(inReady), .inEofc(inEofc), .inData(inData),
    .inStop(inStop), .outReady(outReady), .outEofc(outEofc), .outData(outData), .outStop(outStop)
  );
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive();
    for (int c = 0; c < NI; c++) begin
      inReady[c] = src[c].size() != 0;
      if (src[c].size() != 0) begin
        inEofc[c*8 +: 8] = src[c][0].eofc;
        inData[c*DW +: DW] = src[c][0].data;
      end else begin
        inEofc[c*8 +: 8] = 8'h0;
        inData[c*DW +: DW] = '0;
      end
    end
  endtask
  task automatic clear_tb();
    for (int c = 0; c < NI; c++) begin
      src[c].delete();
      acc_cnt[c] = 0;
    end
    sb.delete();
    frames.delete();
    in_frame = 0;
    out_mid = 0;
    occ = 0;
    cur = 0;
    toggle_stop = 0;
    watch_skid = 0;
    outStop = 1'b0;
    took = '0;
  endtask
  task automatic load_frame(input int c, input int n, input logic [7:0] eofc);
    flit_t f;
    for (int k = 0; k < n; k++) begin
      f.data = '0;
      f.data[DW-1 -: 32] = $urandom;
      f.data[15:0] = {8'(c), 8'(seq)};
      seq++;
      f.eofc = (k == n - 1) ? eofc : 8'h0;
      src[c].push_back(f);
    end
  endtask
  // one clock: sample handshakes at negedge, update sources after the edge
  task automatic step();
    logic [NI-1:0] m;
    int xfer;
    @(negedge clk);
    took = inReady & ~inStop;
    if (in_frame) begin
      m = inStop;
      m[cur] = 1'b1;
      chk("others_stopped", W'(m), W'({NI{1'b1}}));
      if (watch_skid) chk("granted_stop", W'(inStop[cur]), W'(occ == 2));
    end
    for (int c = 0; c < NI; c++) begin
      if (took[c]) begin
        acc_cnt[c]++;
        if (!in_frame) begin
          in_frame = 1;
          cur = c;
        end else chk("accept_granted", W'(c), W'(cur));
        sb.push_back(src[c][0]);
        if (src[c][0].eofc != 8'h0) in_frame = 0;
      end
    end
    xfer = 0;
    if (outReady && !outStop) begin
      xfer = 1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_flit got %0h expected none", {outEofc, outData});
      end else chk("flit", {outEofc, outData}, sb.pop_front());
      if (!out_mid) frame_tag = int'(outData[15:8]);
      else chk("no_interleave", W'(outData[15:8]), W'(frame_tag));
      out_mid = outEofc == 8'h0;
      if (outEofc != 8'h0) frames.push_back(frame_tag);
    end
    occ += $countones(took) - xfer;
    @(posedge clk);
    #1;
    for (int c = 0; c < NI; c++) if (took[c]) void'(src[c].pop_front());
    outStop = toggle_stop ? ~outStop : 1'b0;
    drive();
  endtask
  task automatic run_drain(input int budget);
    int k;
    bit busy;
    for (k = 0; k < budget; k++) begin
      busy = sb.size() != 0;
      for (int c = 0; c < NI; c++) if (src[c].size() != 0) busy = 1;
      if (!busy) break;
      step();
    end
    chk("drain_budget", W'(k < budget), W'(1));
    repeat (3) step();
  endtask
  task automatic check_order(input string name, input int n, input logic [31:0] ord);
    chk({name, "_frames"}, W'(frames.size()), W'(n));
    for (int k = 0; k < n && k < frames.size(); k++)
      chk($sformatf("%s_frame%0d", name, k), W'(frames[k]), W'(ord[k*4 +: 4]));
  endtask
  task automatic do_reset();
    arstN = 1'b0;
    clear_tb();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    arstN = 1'b1;
  endtask
  initial begin
    flit_t exp0;
`ifdef SMI_ARB_FIXED_PRIORITY_EN
    vt[0] = '{4'hF, 8'd3, 8'd2, 8'h10, 1'b0, 8'd8, 32'h33221100};
    vt[1] = '{4'hA, 8'd1, 8'd3, 8'h05, 1'b0, 8'd6, 32'h00333111};
    vt[2] = '{4'h4, 8'd8, 8'd1, 8'h10, 1'b1, 8'd1, 32'h00000002};
    vt[3] = '{4'hC, 8'd2, 8'd2, 8'h07, 1'b0, 8'd4, 32'h00003322};
    vt[4] = '{4'h5, 8'd2, 8'd2, 8'h0F, 1'b0, 8'd4, 32'h00002200};
`else
    vt[0] = '{4'hF, 8'd3, 8'd2, 8'h10, 1'b0, 8'd8, 32'h32103210};
    vt[1] = '{4'hA, 8'd1, 8'd3, 8'h05, 1'b0, 8'd6, 32'h00313131};
    vt[2] = '{4'h4, 8'd8, 8'd1, 8'h10, 1'b1, 8'd1, 32'h00000002};
    vt[3] = '{4'hC, 8'd2, 8'd2, 8'h07, 1'b0, 8'd4, 32'h00003232};
    vt[4] = '{4'h5, 8'd2, 8'd2, 8'h0F, 1'b0, 8'd4, 32'h00002020};
`endif
    // reset with every input requesting, then two-cycle first-flit latency
    arstN = 1'b0;
    clear_tb();
    for (int c = 0; c < NI; c++) load_frame(c, 3, 8'h10);
    drive();
    exp0 = src[0][0];
    @(posedge clk);
    #1;
    chk("reset_outReady", W'(outReady), W'(0));
    chk("reset_inStop", W'(inStop), W'(4'hF));
    chk("reset_outEofc", W'(outEofc), W'(0));
    chk("reset_outData", W'(outData), W'(0));
    @(negedge clk);
    arstN = 1'b1;
    @(posedge clk);
    #1;
    chk("arb_cycle_outReady", W'(outReady), W'(0));
    chk("arb_cycle_inStop", W'(inStop), W'(4'b1110));
    step();
    chk("first_flit_outReady", W'(outReady), W'(1));
    chk("first_flit_value", {outEofc, outData}, exp0);
    run_drain(300);
    check_order("reset_seq", 4, 32'h3210);
    for (int v = 0; v < 5; v++) begin
      do_reset();
      toggle_stop = vt[v].stop;
      watch_skid = vt[v].stop;
      for (int f = 0; f < int'(vt[v].nfr); f++)
        for (int c = 0; c < NI; c++)
          if (vt[v].req[c]) load_frame(c, int'(vt[v].nflit), vt[v].eofc);
      drive();
      run_drain(600);
      check_order($sformatf("vec%0d", v), int'(vt[v].n), vt[v].order);
    end
    // mid-frame reset: pointer moved past 2, reset must bring it back to 0
    do_reset();
    load_frame(2, 2, 8'h10);
    drive();
    run_drain(100);
    load_frame(0, 4, 8'h10);
    drive();
    for (int k = 0; k < 50 && acc_cnt[0] < 2; k++) step();
    chk("midframe_progress", W'(acc_cnt[0] >= 2), W'(1));
    arstN = 1'b0;
    #1;
    chk("midreset_outReady", W'(outReady), W'(0));
    chk("midreset_inStop", W'(inStop), W'(4'hF));
    chk("midreset_outData", W'(outData), W'(0));
    clear_tb();
    drive();
    @(negedge clk);
    arstN = 1'b1;
    load_frame(1, 2, 8'h10);
    load_frame(3, 2, 8'h10);
    drive();
    run_drain(200);
    check_order("after_reset", 2, 32'h31);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/smi_frame_arbiter_xn.md
Name: smi_frame_arbiter_xn

Overview:
- Parametrised N-input SMI frame arbiter that merges NumInputs SMI flit streams onto one SMI output.
- Frames are never interleaved; a grant is held until the end-of-frame flit.
- Successor to the fixed two-input response arbiter; used to merge responses from multiple memory adaptors and multiple request sources onto one bus adaptor.
- Adds round-robin fairness, a configurable input count and a registered two-entry output skid stage.

Parameters:
- NumInputs, 4, number of SMI input channels (2..16).
- FlitWidth, 16, flit width in bytes (>=16); data width is FlitWidth*8.
- GrantWidth, $clog2(NumInputs), width of the grant index (derived; do not override).

Ports:
- clk  input  1  clock.
- arstN  input  1  reset; one clock, asynchronous assert, active-low; deassertion synchronised externally.
- inReady  input  NumInputs  per-channel flit valid.
- inEofc  input  8*NumInputs  per-channel end-of-frame control; channel i occupies bits [8i+7:8i].
- inData  input  FlitWidth*8*NumInputs  per-channel flit data, packed by channel as for inEofc.
- inStop  output  NumInputs  per-channel backpressure.
- outReady  output  1  output flit valid.
- outEofc  output  8  output end-of-frame control.
- outData  output  FlitWidth*8  output flit data.
- outStop  input  1  downstream backpressure.

Behaviour:
- Transfer rules:
  - A flit transfers on any port when Ready=1 and Stop=0 at a rising clk edge.
  - Eofc=0 marks a mid-frame flit; Eofc!=0 marks the last flit (valid byte count, 0 encodes full).
  - Eofc and Data pass through unmodified.
- Reset (arstN=0, takes effect immediately):
  - outReady=0, outEofc=0, outData=0, inStop=all ones.
  - state=IDLE, rrPtr=0, skid count=0.
- FSM states IDLE and LOCKED.
  - IDLE:
    - inStop all ones.
    - If any inReady=1, select the winner (round-robin search starting at rrPtr), register grant, go to LOCKED.
    - No flit is accepted in the arbitration cycle.
  - LOCKED:
    - inStop[grant] = skid full (registered); all other inStop=1.
    - On acceptance of a flit from the granted input with Eofc!=0: go to IDLE, rrPtr = (grant+1) mod NumInputs.
- Latency:
  - First flit of a frame reaches outReady 2 cycles after inReady rises with the arbiter in IDLE: 1 cycle arbitration, 1 cycle register.
  - Subsequent flits: 1 cycle.
  - One idle input cycle between frames (the re-arbitration bubble) is required and acceptable.
- Skid stage (2 entries, registered outputs):
  - Sustains 1 flit/cycle with outStop=0.
  - Asserts the granted inStop only when holding 2 entries.
  - Never drops or duplicates a flit when outStop toggles every cycle.
- Boundary conditions:
  - Single-flit frames (Eofc!=0 on the first flit) are legal.
  - inReady dropping mid-frame on the granted input holds the grant; no timeout.
  - Non-granted inputs asserting Ready are ignored and see Stop=1.
  - rrPtr wraps from NumInputs-1 to 0.
  - Skid entries already captured drain after the FSM returns to IDLE; the next frame's flits queue behind them in order.
  - Reset mid-frame: the frame is truncated; skid contents are discarded; rrPtr returns to 0.

Optional Feature:
- Macro SMI_ARB_FIXED_PRIORITY_EN.
- When defined: the IDLE search always starts at input 0 (lowest index wins); rrPtr logic is removed.
- When undefined: round-robin as above.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package smi_pkg holds:
  - SMI_EOFC_WIDTH=8 and the flit-width helpers.
  - The arbiter state enum (IDLE, LOCKED).
  - Frame type ID constants: write request 0x01, read request 0x02, ID byte mask 0xFF.
- Sub-module smi_flit_skid_buffer: 2-entry Ready/Stop buffer for Eofc+Data, reusable by the steer and adaptor blocks.

Test Plan:
1. Reset: hold arstN=0 with all inReady=1 -> outReady=0, inStop=4'b1111; after release, first flit on outReady in cycle 2.
2. Round-robin: inputs 0..3 each continuously offer 3-flit frames with Data tagged by channel -> output frame order 0,1,2,3,0; flits never interleave; each frame's last flit has its Eofc intact (e.g. 0x10).
3. Backpressure: single 8-flit frame on input 2 with outStop toggled on alternate cycles -> all 8 flits in order, no duplicates; inStop[2] high only while skid holds 2 entries.
4. Single-flit frames: inputs 1 and 3 send Eofc=0x05 single flits repeatedly -> alternating 1,3,1,3 with one bubble per frame; outEofc=0x05.
5. Mid-frame reset: assert arstN=0 after flit 2 of a 4-flit frame on input 0 -> outReady=0 immediately; after release, input 1 requesting wins first, from rrPtr=0.
6. SMI_ARB_FIXED_PRIORITY_EN build: inputs 0 and 2 both continuously requesting -> only input 0 frames are output; input 2 is starved with inStop[2]=1.
